// File: rtl/divide_f32_sched_pkg.sv
// Shared definitions for the divide_f32 scheduler.
//   state_t      : scheduler FSM states
//   F32_INF      : +infinity encoding
//   F32_QNAN     : canonical quiet NaN used for 0/0 and fault results
//   f32_is_zero  : true for +0 and -0
package divide_f32_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_BUSY   = 3'd2,
    S_ZERO   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] F32_INF  = 32'h7f800000;
  localparam logic [31:0] F32_QNAN = 32'h7fc00000;

  function automatic logic f32_is_zero(input logic [31:0] x);
    return (x[30:0] == 31'd0);
  endfunction

endpackage

// File: rtl/divide_f32_sched_rr_pick.sv
// Round-robin pick: finds the first asserted request at or after the
// pointer, wrapping at N_REQ.
//   i_req    : request vector
//   i_ptr    : lane with highest priority this round
//   o_onehot : one-hot winner (zero when no request)
//   o_idx    : winner index
//   o_any    : at least one request present
module divide_f32_sched_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  // Scan from farthest to nearest so the lane closest to the pointer
  // is the last (winning) assignment.
  always_comb begin
    int j;
    j        = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (i_req[j]) begin
        o_onehot    = '0;
        o_onehot[j] = 1'b1;
        o_idx       = IW'(j);
        o_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divide_f32_sched.sv
// Round-robin scheduler sharing one divide_f32 unit among N_REQ lanes.
// The winner's operands are latched, the divider is started by holding
// div_rst high for START_CYC cycles, and the quotient is returned with a
// one-cycle done pulse. Zero denominators are resolved locally.
//
// Handshake: a lane raises req[i] and holds it (and its operands) until it
// sees done[i]; operands are sampled once at grant. done[i] is a single
// cycle pulse with quo/err valid; quo holds until the next done. There is
// no backpressure on done: the requester must take the result that cycle.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   req, num_bus, den_bus  lane requests and packed float32 operands
//   gnt, done, quo, err    grant, completion pulse, result, fault flag
//   busy              scheduler not idle
//   div_rst, div_num, div_den, div_rdy, div_quo  shared divider interface
//   dbg_state         current FSM state (state_t encoding)
//
// Build option: DIV_SCHED_TIMEOUT_EN adds a LAUNCH+BUSY watchdog of
// TIMEOUT cycles that returns a quiet NaN with err=1.
module divide_f32_sched
  import divide_f32_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int START_CYC = 1,
  parameter int TIMEOUT   = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] num_bus,
  input  logic [32*N_REQ-1:0] den_bus,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [31:0]         quo,
  output logic                err,
  output logic                busy,
  output logic                div_rst,
  output logic [31:0]         div_num,
  output logic [31:0]         div_den,
  input  logic                div_rdy,
  input  logic [31:0]         div_quo,
  output logic [2:0]          dbg_state
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(START_CYC + 1);

  state_t            r_state, w_next;
  logic [IW-1:0]     r_ptr, r_lane;
  logic [N_REQ-1:0]  r_gnt, r_done;
  logic [31:0]       r_num, r_den, r_res, r_quo;
  logic              r_res_err, r_err;
  logic [SW-1:0]     r_start_cnt;
  logic              r_in_busy;

  logic [N_REQ-1:0]  w_onehot;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic [31:0]       w_num_sel, w_den_sel;
  logic              w_timeout;

  divide_f32_sched_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign w_num_sel = num_bus[{w_idx, 5'd0} +: 32];
  assign w_den_sel = den_bus[{w_idx, 5'd0} +: 32];

`ifdef DIV_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;
  // Counter value equals the number of LAUNCH+BUSY cycles already spent.
  assign w_timeout = (r_state == S_BUSY) && (r_to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_to_cnt <= '0;
    else if (r_state == S_IDLE) r_to_cnt <= '0;
    else if (r_state == S_LAUNCH || r_state == S_BUSY) r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = f32_is_zero(w_den_sel) ? S_ZERO : S_LAUNCH;
      S_LAUNCH: if (r_start_cnt == SW'(START_CYC - 1)) w_next = S_BUSY;
      // r_in_busy masks a stale div_rdy in the first BUSY cycle.
      S_BUSY:   if ((r_in_busy && div_rdy) || w_timeout) w_next = S_DONE;
      S_ZERO:   w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_lane      <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_num       <= '0;
      r_den       <= '0;
      r_res       <= '0;
      r_quo       <= '0;
      r_res_err   <= 1'b0;
      r_err       <= 1'b0;
      r_start_cnt <= '0;
      r_in_busy   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_done    <= '0;
      r_in_busy <= (r_state == S_BUSY);
      case (r_state)
        S_IDLE: if (w_any) begin
          r_gnt       <= w_onehot;
          r_lane      <= w_idx;
          r_num       <= w_num_sel;
          r_den       <= w_den_sel;
          r_start_cnt <= '0;
          r_res_err   <= 1'b0;
        end
        S_LAUNCH: r_start_cnt <= r_start_cnt + 1'b1;
        S_BUSY: begin
          if (r_in_busy && div_rdy) begin
            r_res     <= div_quo;
            r_res_err <= 1'b0;
          end else if (w_timeout) begin
            r_res     <= F32_QNAN;
            r_res_err <= 1'b1;
          end
        end
        S_ZERO: r_res <= f32_is_zero(r_num) ? F32_QNAN
                                             : {r_num[31] ^ r_den[31], F32_INF[30:0]};
        S_DONE: begin
          r_done <= N_REQ'(1) << r_lane;
          r_gnt  <= '0;
          r_quo  <= r_res;
          r_err  <= r_res_err;
          r_ptr  <= (r_lane == IW'(N_REQ - 1)) ? '0 : r_lane + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign quo       = r_quo;
`ifdef DIV_SCHED_TIMEOUT_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif
  assign busy      = (r_state != S_IDLE);
  assign div_rst   = (r_state != S_BUSY);
  assign div_num   = r_num;
  assign div_den   = r_den;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_divide_f32_sched.sv
// Directed bench for divide_f32_sched with a behavioural divider stand-in:
// the divider returns a fixed-latency table result once div_rst drops.
module tb_divide_f32_sched;

  localparam int N   = 4;
  localparam int SC  = 2;
  localparam int TO  = 16;
  localparam int LAT = 4;

  logic           clk, rst;
  logic [N-1:0]   req;
  logic [32*N-1:0] num_bus, den_bus;
  logic [N-1:0]   gnt, done;
  logic [31:0]    quo, div_num, div_den, div_quo;
  logic           err, busy, div_rst, div_rdy;
  logic [2:0]     dbg_state;

  int vec_cnt, err_cnt;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  divide_f32_sched #(.N_REQ(N), .START_CYC(SC), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .num_bus   (num_bus),
    .den_bus   (den_bus),
    .gnt       (gnt),
    .done      (done),
    .quo       (quo),
    .err       (err),
    .busy      (busy),
    .div_rst   (div_rst),
    .div_num   (div_num),
    .div_den   (div_den),
    .div_rdy   (div_rdy),
    .div_quo   (div_quo),
    .dbg_state (dbg_state)
  );

  // ---------------- divider stand-in ----------------
  logic stall;
  int   m_cnt;

  function automatic logic [31:0] div_table(input logic [31:0] n, input logic [31:0] d);
    case ({n, d})
      64'h40800000_40000000: return 32'h40000000;  // 4/2
      64'h40800000_40400000: return 32'h3faaaaab;  // 4/3
      64'h3f800000_40000000: return 32'h3f000000;  // 1/2
      64'h40400000_3f800000: return 32'h40400000;  // 3/1
      default:               return 32'hdeadbeef;
    endcase
  endfunction

  always @(posedge clk) begin
    if (div_rst) begin
      m_cnt   <= 0;
      div_rdy <= 1'b0;
      div_quo <= 32'h0;
    end else if (!div_rdy && !stall) begin
      if (m_cnt == LAT - 1) begin
        div_rdy <= 1'b1;
        div_quo <= div_table(div_num, div_den);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Counts cycles where the divider is out of reset, while enabled.
  logic mon_on;
  int   rst_low;
  always @(negedge clk) if (mon_on && !div_rst) rst_low <= rst_low + 1;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic [31:0] n, input logic [31:0] d);
    num_bus[32*i +: 32] = n;
    den_bus[32*i +: 32] = d;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc,
                           output logic [N-1:0] d, output logic ok);
    cyc = 0;
    ok  = 1'b0;
    d   = '0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        d  = done;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    req = '0;
    repeat (2) tick();
    vec_cnt++; if (gnt !== 4'b0)      begin err_cnt++; $display("FAIL reset_gnt got %h want 0", gnt); end
    vec_cnt++; if (done !== 4'b0)     begin err_cnt++; $display("FAIL reset_done got %h want 0", done); end
    vec_cnt++; if (quo !== 32'h0)     begin err_cnt++; $display("FAIL reset_quo got %h want 0", quo); end
    vec_cnt++; if (err !== 1'b0)      begin err_cnt++; $display("FAIL reset_err got %b want 0", err); end
    vec_cnt++; if (busy !== 1'b0)     begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
    vec_cnt++; if (div_rst !== 1'b1)  begin err_cnt++; $display("FAIL reset_div_rst got %b want 1", div_rst); end
    vec_cnt++; if (div_num !== 32'h0 || div_den !== 32'h0)
      begin err_cnt++; $display("FAIL reset_div_ops got %h/%h want 0/0", div_num, div_den); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_divide();
    int cyc; logic [N-1:0] d; logic ok;
    set_lane(0, 32'h40800000, 32'h40000000);
    req = 4'b0001;
    wait_done(50, cyc, d, ok);
    req = '0;
    vec_cnt++; if (!ok)               begin err_cnt++; $display("FAIL div_timeout no done within 50 cycles"); end
    vec_cnt++; if (d !== 4'b0001)     begin err_cnt++; $display("FAIL div_done got %b want 0001", d); end
    vec_cnt++; if (quo !== 32'h40000000) begin err_cnt++; $display("FAIL div_quo got %h want 40000000", quo); end
    vec_cnt++; if (err !== 1'b0)      begin err_cnt++; $display("FAIL div_err got %b want 0", err); end
    // grant edge + SC launch + LAT divider + stale-rdy cycle + DONE
    vec_cnt++; if (cyc != 1 + SC + LAT + 2) begin err_cnt++; $display("FAIL div_latency got %0d want %0d", cyc, 1 + SC + LAT + 2); end
    tick();
    vec_cnt++; if (done !== 4'b0)     begin err_cnt++; $display("FAIL div_done_pulse got %b want 0", done); end
    vec_cnt++; if (quo !== 32'h40000000) begin err_cnt++; $display("FAIL div_quo_hold got %h want 40000000", quo); end
  endtask

  task automatic test_launch_window();
    int cyc, n_hi; logic [N-1:0] d; logic ok, low_seen;
    set_lane(1, 32'h40800000, 32'h40400000);
    req = 4'b0010;
    n_hi = 0; low_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!div_rst) begin low_seen = 1'b1; break; end
      if (busy) n_hi++;
    end
    vec_cnt++; if (!low_seen)         begin err_cnt++; $display("FAIL launch_start div_rst never dropped"); end
    vec_cnt++; if (n_hi != SC)        begin err_cnt++; $display("FAIL launch_width got %0d want %0d", n_hi, SC); end
    vec_cnt++; if (gnt !== 4'b0010)   begin err_cnt++; $display("FAIL launch_gnt got %b want 0010", gnt); end
    wait_done(50, cyc, d, ok);
    req = '0;
    vec_cnt++; if (!ok || d !== 4'b0010) begin err_cnt++; $display("FAIL launch_done got %b want 0010", d); end
    vec_cnt++; if (quo !== 32'h3faaaaab) begin err_cnt++; $display("FAIL launch_quo got %h want 3faaaaab", quo); end
  endtask

  task automatic test_zero_den();
    logic [31:0] tn [4] = '{32'h4f000000, 32'h00000000, 32'h3f800000, 32'h80000000};
    logic [31:0] td [4] = '{32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000};
    logic [31:0] tq [4] = '{32'hff800000, 32'h7fc00000, 32'h7f800000, 32'h7fc00000};
    int cyc; logic [N-1:0] d; logic ok;
    for (int v = 0; v < 4; v++) begin
      set_lane(2, tn[v], td[v]);
      rst_low = 0;
      mon_on  = 1'b1;
      req = 4'b0100;
      wait_done(20, cyc, d, ok);
      req = '0;
      mon_on = 1'b0;
      vec_cnt++; if (!ok || d !== 4'b0100) begin err_cnt++; $display("FAIL zero_done[%0d] got %b want 0100", v, d); end
      vec_cnt++; if (quo !== tq[v])  begin err_cnt++; $display("FAIL zero_quo[%0d] got %h want %h", v, quo, tq[v]); end
      vec_cnt++; if (cyc != 3)       begin err_cnt++; $display("FAIL zero_latency[%0d] got %0d want 3", v, cyc); end
      vec_cnt++; if (rst_low != 0)   begin err_cnt++; $display("FAIL zero_div_rst[%0d] low for %0d cycles want 0", v, rst_low); end
      tick();
    end
  endtask

  task automatic test_arbitration();
    logic [N-1:0] exp_d [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0]  exp_q [5] = '{32'h40000000, 32'h3faaaaab, 32'h3f000000, 32'h40400000, 32'h40000000};
    int cyc; logic [N-1:0] d; logic ok;
    pulse_reset();
    set_lane(0, 32'h40800000, 32'h40000000);
    set_lane(1, 32'h40800000, 32'h40400000);
    set_lane(2, 32'h3f800000, 32'h40000000);
    set_lane(3, 32'h40400000, 32'h3f800000);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(50, cyc, d, ok);
      if (k == 4) req = '0;
      vec_cnt++; if (!ok || d !== exp_d[k]) begin err_cnt++; $display("FAIL arb_order[%0d] got %b want %b", k, d, exp_d[k]); end
      vec_cnt++; if (quo !== exp_q[k]) begin err_cnt++; $display("FAIL arb_quo[%0d] got %h want %h", k, quo, exp_q[k]); end
    end
    tick();
    // Pointer now sits at lane 1: lane 2 must beat lane 0.
    req = 4'b0101;
    wait_done(50, cyc, d, ok);
    req = 4'b0001;
    vec_cnt++; if (!ok || d !== 4'b0100) begin err_cnt++; $display("FAIL arb_ptr_first got %b want 0100", d); end
    wait_done(50, cyc, d, ok);
    req = '0;
    vec_cnt++; if (!ok || d !== 4'b0001) begin err_cnt++; $display("FAIL arb_ptr_second got %b want 0001", d); end
    vec_cnt++; if (quo !== 32'h40000000) begin err_cnt++; $display("FAIL arb_ptr_quo got %h want 40000000", quo); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int cyc, n_done; logic [N-1:0] d; logic ok, in_busy;
    set_lane(3, 32'h40400000, 32'h3f800000);
    req = 4'b1000;
    in_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy && !div_rst) begin in_busy = 1'b1; break; end
    end
    vec_cnt++; if (!in_busy)          begin err_cnt++; $display("FAIL midrst_busy never reached divider phase"); end
    tick();
    rst = 1'b0;
    tick();
    vec_cnt++; if (gnt !== 4'b0)      begin err_cnt++; $display("FAIL midrst_gnt got %b want 0", gnt); end
    vec_cnt++; if (div_rst !== 1'b1)  begin err_cnt++; $display("FAIL midrst_div_rst got %b want 1", div_rst); end
    vec_cnt++; if (busy !== 1'b0)     begin err_cnt++; $display("FAIL midrst_busy got %b want 0", busy); end
    req = '0;
    rst = 1'b1;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done != '0) n_done++;
    end
    vec_cnt++; if (n_done != 0)       begin err_cnt++; $display("FAIL midrst_done got %0d pulses want 0", n_done); end
    req = 4'b1000;
    wait_done(50, cyc, d, ok);
    req = '0;
    vec_cnt++; if (!ok || d !== 4'b1000) begin err_cnt++; $display("FAIL midrst_after_done got %b want 1000", d); end
    vec_cnt++; if (quo !== 32'h40400000) begin err_cnt++; $display("FAIL midrst_after_quo got %h want 40400000", quo); end
    tick();
  endtask

`ifdef DIV_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int cyc; logic [N-1:0] d; logic ok;
    stall = 1'b1;
    set_lane(0, 32'h40800000, 32'h40000000);
    req = 4'b0001;
    wait_done(60, cyc, d, ok);
    req = '0;
    stall = 1'b0;
    vec_cnt++; if (!ok || d !== 4'b0001) begin err_cnt++; $display("FAIL to_done got %b want 0001", d); end
    vec_cnt++; if (quo !== 32'h7fc00000) begin err_cnt++; $display("FAIL to_quo got %h want 7fc00000", quo); end
    vec_cnt++; if (err !== 1'b1)      begin err_cnt++; $display("FAIL to_err got %b want 1", err); end
    // grant edge + TO cycles in LAUNCH+BUSY + DONE
    vec_cnt++; if (cyc != TO + 2)     begin err_cnt++; $display("FAIL to_latency got %0d want %0d", cyc, TO + 2); end
    tick();
    set_lane(1, 32'h40800000, 32'h40400000);
    req = 4'b0010;
    wait_done(50, cyc, d, ok);
    req = '0;
    vec_cnt++; if (!ok || err !== 1'b0) begin err_cnt++; $display("FAIL to_err_clear got %b want 0", err); end
    vec_cnt++; if (quo !== 32'h3faaaaab) begin err_cnt++; $display("FAIL to_next_quo got %h want 3faaaaab", quo); end
    tick();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0; req = '0; num_bus = '0; den_bus = '0;
    stall = 1'b0; mon_on = 1'b0; rst_low = 0;
    vec_cnt = 0; err_cnt = 0;
    test_reset();
    test_divide();
    test_launch_window();
    test_zero_den();
    test_arbitration();
    test_reset_mid_op();
`ifdef DIV_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
